// File: rtl/ahb_mem_pkg.sv
// Shared AHB encodings, FSM state codes and byte-lane helpers for the ahb_mem_ss slave.
package ahb_mem_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        RespOkay  = 2'b00,
        RespError = 2'b01
    } hresp_t;

    localparam logic [2:0] SizeByte  = 3'd0;
    localparam logic [2:0] SizeHalf  = 3'd1;
    localparam logic [2:0] SizeWord  = 3'd2;
    localparam logic [2:0] SizeDword = 3'd3;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StWait = 2'd1;
    localparam state_t StErr1 = 2'd2;
    localparam state_t StErr2 = 2'd3;

    // Lane mask of a transfer at byte offset 0; the caller shifts it by the offset.
    function automatic logic [7:0] size_lanes(input logic [2:0] size);
        logic [7:0] lanes;
        case (size)
            SizeByte: lanes = 8'h01;
            SizeHalf: lanes = 8'h03;
            SizeWord: lanes = 8'h0f;
            default:  lanes = 8'hff;
        endcase
        return lanes;
    endfunction

    function automatic logic [2:0] align_mask(input logic [2:0] size);
        logic [2:0] mask;
        case (size)
            SizeByte: mask = 3'b000;
            SizeHalf: mask = 3'b001;
            SizeWord: mask = 3'b011;
            default:  mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Byte-enabled DEPTH x DATA_W storage with one write port and a registered read port.
module ahb_mem_array
    import ahb_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents survive HRESET. A same-edge read returns the old word.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (we_i && be_i[i]) begin
                mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/ahb_mem_ss.sv
// AHB-Lite memory slave: protocol FSM, wait-state counter and write-to-read forwarding.
// Define AHB_MEM_SS_PRIV_CHECK_EN to reject unprivileged accesses below PRIV_LIMIT.
module ahb_mem_ss
    import ahb_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned PRIV_LIMIT  = 'h100
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [DATA_W-1:0] HRDATA,
    output logic [1:0]        HRESP
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(NB);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dp_valid_q, dp_valid_d;
    logic               dp_write_q;
    logic [AW-1:0]      dp_word_q;
    logic [OFF_W-1:0]   dp_off_q;
    logic [2:0]         dp_size_q;
    logic [NB-1:0]      fwd_be_q;
    logic [DATA_W-1:0]  fwd_data_q;

    logic               ready, accept, legal, complete;
    logic               addr_oob, size_bad, misalign, priv_bad;
    logic               wr_en, rd_en;
    logic [NB-1:0]      wr_be;
    logic [AW-1:0]      rd_word;
    logic [DATA_W-1:0]  mem_rdata, rd_merged;
    logic               unused_ok;

    assign ready    = (state_q == StIdle) || (state_q == StErr2);
    assign accept   = HSEL && HTRANS[1] && HREADY && ready && !HRESET;
    assign complete = (state_q == StIdle) && dp_valid_q;

    assign addr_oob = 64'(HADDR) >= MEM_BYTES;
    assign size_bad = HSIZE > 3'(OFF_W);
    assign misalign = (HADDR[2:0] & align_mask(HSIZE)) != 3'b000;

`ifdef AHB_MEM_SS_PRIV_CHECK_EN
    assign priv_bad  = !HPROT[1] && (64'(HADDR) < 64'(PRIV_LIMIT));
    assign unused_ok = ^{HBURST, HPROT[3:2], HPROT[0], HTRANS[0]};
`else
    assign priv_bad  = 1'b0;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], 32'(PRIV_LIMIT)};
`endif

    assign legal = !(addr_oob || size_bad || misalign || priv_bad);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        case (state_q)
            StWait: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StErr1: state_d = StErr2;
            default: begin
                // IDLE and ERR2 both end a data phase and may start the next one.
                state_d    = StIdle;
                dp_valid_d = 1'b0;
                if (accept) begin
                    cnt_d = CNT_W'(WAIT_STATES);
                    if (!legal) begin
                        state_d = StErr1;
                    end else begin
                        dp_valid_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = StWait;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            dp_write_q <= HWRITE;
            dp_word_q  <= HADDR[OFF_W +: AW];
            dp_off_q   <= HADDR[OFF_W-1:0];
            dp_size_q  <= HSIZE;
        end
        // The array read samples stale data when a write lands on the same edge.
        if (rd_en) begin
            fwd_be_q   <= (wr_en && (dp_word_q == rd_word)) ? wr_be : '0;
            fwd_data_q <= HWDATA;
        end
    end

    assign wr_be   = NB'(size_lanes(dp_size_q)) << dp_off_q;
    assign wr_en   = complete && dp_write_q && !HRESET;
    assign rd_en   = accept && legal && !HWRITE;
    assign rd_word = HADDR[OFF_W +: AW];

    ahb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk_i   (HCLK),
        .we_i    (wr_en),
        .waddr_i (dp_word_q),
        .be_i    (wr_be),
        .wdata_i (HWDATA),
        .re_i    (rd_en),
        .raddr_i (rd_word),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        rd_merged = mem_rdata;
        for (int i = 0; i < NB; i++) begin
            if (fwd_be_q[i]) begin
                rd_merged[i*8 +: 8] = fwd_data_q[i*8 +: 8];
            end
        end
    end

    assign HREADYOUT = ready;
    assign HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? RespError : RespOkay;
    assign HRDATA    = (complete && !dp_write_q) ? rd_merged : '0;

endmodule
